// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory / MMIO slave: register offsets,
// STATUS field positions and the address-decode select type.
package mmio_pkg;

  localparam logic [15:0] CONSOLE_TX     = 16'h0000;
  localparam logic [15:0] CONSOLE_STATUS = 16'h0004;
  localparam logic [15:0] TOHOST         = 16'h0008;
  localparam logic [15:0] CYCLE          = 16'h000C;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 5;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_TOHOST,
    SEL_CYCLE,
    SEL_NONE
  } mmio_sel_e;

endpackage

// File: rtl/console_fifo.sv
// Console transmit FIFO: circular buffer with occupancy count; a push while
// full is only accepted when a pop frees a slot in the same cycle.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCount = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             doPop;
  logic             doPush;

  assign empty  = (count == '0);
  assign full   = (count == FullCount);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign drop   = push & full & ~doPop;
  assign head   = slots[rdPtr];

  // Slots are cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (doPush) begin
        slots[wrPtr] <= push_data;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory slave for the 5-stage core: word RAM plus an MMIO window with
// console TX FIFO, sticky TOHOST halt register and a free-running cycle counter.
module dmem_mmio #(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wd,
  output logic [31:0] dmem_rd,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  import mmio_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mmio_sel_e        sel;
  logic [AW-1:0]    ramIdx;
  logic [31:0]      ram [MEM_WORDS];
  logic             weLive;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             fifoDrop;
  logic [CW-1:0]    fifoCount;
  logic             overflow;
  logic [31:0]      cycle;
  logic [31:0]      statusWord;
  logic             unusedAddrBits;

  assign unusedAddrBits = ^dmem_addr[1:0];
  assign ramIdx         = dmem_addr[2 +: AW];
  assign weLive         = dmem_we & ~halt;
  assign console_valid  = ~fifoEmpty;

  // Byte offset bits [1:0] are ignored, so only the word offset is matched.
  always_comb begin
    sel = SEL_NONE;
    if (dmem_addr[31:16] != MMIO_BASE[31:16]) begin
      sel = SEL_RAM;
    end else begin
      case ({dmem_addr[15:2], 2'b00})
        CONSOLE_TX:     sel = SEL_TX;
        CONSOLE_STATUS: sel = SEL_STATUS;
        TOHOST:         sel = SEL_TOHOST;
        CYCLE:          sel = SEL_CYCLE;
        default:        sel = SEL_NONE;
      endcase
    end
  end

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (weLive && (sel == SEL_TX)),
    .push_data (dmem_wd[7:0]),
    .pop       (console_valid & console_ready),
    .head      (console_data),
    .empty     (fifoEmpty),
    .full      (fifoFull),
    .count     (fifoCount),
    .drop      (fifoDrop)
  );

  always_ff @(posedge clk) begin
    if (weLive && (sel == SEL_RAM)) begin
      ram[ramIdx] <= dmem_wd;
    end
  end

  // Halt freezes the counter and blocks all writes; only reset releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt      <= 1'b0;
      halt_code <= '0;
      cycle     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (!halt) begin
        cycle <= cycle + 1'b1;
      end
      if (weLive && (sel == SEL_TOHOST)) begin
        halt      <= 1'b1;
        halt_code <= dmem_wd;
      end
      if (fifoDrop) begin
        overflow <= 1'b1;
      end else if (weLive && (sel == SEL_STATUS) && dmem_wd[STATUS_OVF_BIT]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    statusWord                                      = '0;
    statusWord[STATUS_COUNT_LSB +: STATUS_COUNT_W]  = STATUS_COUNT_W'(fifoCount);
    statusWord[STATUS_OVF_BIT]                      = overflow;
    statusWord[STATUS_FULL_BIT]                     = fifoFull;
    statusWord[STATUS_EMPTY_BIT]                    = fifoEmpty;
  end

  always_comb begin
    dmem_rd = '0;
    case (sel)
      SEL_RAM:    dmem_rd = ram[ramIdx];
      SEL_STATUS: dmem_rd = statusWord;
      SEL_TOHOST: dmem_rd = halt_code;
      SEL_CYCLE:  dmem_rd = cycle;
      default:    dmem_rd = '0;
    endcase
  end

endmodule
